// File: rtl/sd_clock_gen.sv
// SDCLK generator in the 2x base clock domain: divided/programmable half-period,
// stop/pause only at phase ends with full low phases, registered edge strobes.
module sd_clock_gen #(
  parameter int DivWidth = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                power_i,
  input  logic                enable_i,
  input  logic                pause_i,
  input  logic                mode_i,
  input  logic [DivWidth-1:0] freq_i,
  output logic                sdclk_o,
  output logic                rise_o,
  output logic                fall_o,
  output logic                active_o
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [DivWidth:0] ONE = {{DivWidth{1'b0}}, 1'b1};

  state_t            state;
  logic [DivWidth:0] half;
  logic [DivWidth:0] count;
  logic              stop;

  assign stop = !enable_i || pause_i;

  // Half-period in clk_i cycles; one extra bit so the largest setting cannot wrap.
  always_comb begin
    half = ONE;
    if (mode_i) begin
      half = {1'b0, freq_i} + ONE;
    end else if (freq_i != '0) begin
      half = {freq_i, 1'b0};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      count    <= ONE;
      sdclk_o  <= 1'b0;
      rise_o   <= 1'b0;
      fall_o   <= 1'b0;
      active_o <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      if (!power_i) begin
        state    <= IDLE;
        count    <= ONE;
        sdclk_o  <= 1'b0;
        active_o <= 1'b0;
        fall_o   <= sdclk_o;
      end else begin
        case (state)
          // count > 1 here means a low phase carried over from a stop is still running
          IDLE: begin
            if (count > ONE) begin
              count <= count - ONE;
            end else if (!stop) begin
              state    <= HIGH;
              count    <= half;
              sdclk_o  <= 1'b1;
              rise_o   <= 1'b1;
              active_o <= 1'b1;
            end
          end
          HIGH: begin
            if (count == ONE) begin
              state    <= stop ? IDLE : LOW;
              count    <= half;
              sdclk_o  <= 1'b0;
              fall_o   <= 1'b1;
              active_o <= !stop;
            end else begin
              count <= count - ONE;
            end
          end
          LOW: begin
            if (count == ONE) begin
              if (stop) begin
                state    <= IDLE;
                count    <= ONE;
                active_o <= 1'b0;
              end else begin
                state   <= HIGH;
                count   <= half;
                sdclk_o <= 1'b1;
                rise_o  <= 1'b1;
              end
            end else begin
              count <= count - ONE;
            end
          end
          default: begin
            state    <= IDLE;
            count    <= ONE;
            sdclk_o  <= 1'b0;
            active_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
